gpio_frame_sampler: RTL and testbench

//   Parametrised successor to the single-buffer GPIO snapshot logic. Samples a DATA_W-bit

---
 rtl/gpio_frame_sampler_if.sv | 25 ++
 rtl/gpio_frame_sampler.sv | 113 +++++++++++
 tb/tb_gpio_frame_sampler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_frame_sampler_if.sv
// Frame publication bus between the GPIO frame sampler (master) and the packet builder (slave).
interface gpio_frame_sampler_if #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 18,
    parameter int SEQ_W     = 8
);
    localparam int AW = $clog2(FRAME_LEN);

    logic              frame_valid;
    logic              frame_ack;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [SEQ_W-1:0]  frame_seq;
    logic [7:0]        overrun_cnt;

    modport master (
        output frame_valid, rd_data, frame_seq, overrun_cnt,
        input  frame_ack, rd_addr
    );

    modport slave (
        input  frame_valid, rd_data, frame_seq, overrun_cnt,
        output frame_ack, rd_addr
    );
endinterface

// File: rtl/gpio_frame_sampler.sv
// Samples a GPIO bus every SAMPLE_DIV clocks into FRAME_LEN-sample frames held in a ping-pong
// buffer and publishes each complete frame over a valid/ack handshake with random read access.
module gpio_frame_sampler #(
    parameter int DATA_W     = 16,
    parameter int FRAME_LEN  = 18,
    parameter int SAMPLE_DIV = 556,
    parameter int SEQ_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    gpio_frame_sampler_if.master bus
);
    localparam int AW     = $clog2(FRAME_LEN);
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int MEM_D  = 2 * FRAME_LEN;
    localparam int MEM_AW = $clog2(MEM_D);

    typedef enum logic {EMPTY, PUBLISHED} state_t;

    state_t            state;
    logic [DATA_W-1:0] sync1;
    logic [DATA_W-1:0] sync2;
    logic [DIV_W-1:0]  div;
    logic [AW-1:0]     fill_idx;
    logic              fill_bank;
    logic              read_bank;
    logic [SEQ_W-1:0]  seq_cnt;
    logic [DATA_W-1:0] mem [MEM_D];

    logic              tick;
    logic              complete;
    logic              addr_ok;
    logic [MEM_AW-1:0] wr_addr;
    logic [MEM_AW-1:0] rd_mem_addr;

    assign tick        = enable && (div == DIV_W'(SAMPLE_DIV - 1));
    assign complete    = tick && (fill_idx == AW'(FRAME_LEN - 1));
    assign wr_addr     = fill_bank ? MEM_AW'(FRAME_LEN) + MEM_AW'(fill_idx) : MEM_AW'(fill_idx);
    assign rd_mem_addr = read_bank ? MEM_AW'(FRAME_LEN) + MEM_AW'(bus.rd_addr) : MEM_AW'(bus.rd_addr);
    assign addr_ok     = ({1'b0, bus.rd_addr} < (AW + 1)'(FRAME_LEN));

    // Buffer RAM has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && tick) begin
            mem[wr_addr] <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= EMPTY;
            sync1           <= '0;
            sync2           <= '0;
            div             <= '0;
            fill_idx        <= '0;
            fill_bank       <= 1'b0;
            read_bank       <= 1'b0;
            seq_cnt         <= '0;
            bus.frame_valid <= 1'b0;
            bus.rd_data     <= '0;
            bus.frame_seq   <= '0;
            bus.overrun_cnt <= '0;
        end else begin
            sync1       <= sample_in;
            sync2       <= sync1;
            bus.rd_data <= addr_ok ? mem[rd_mem_addr] : '0;

            if (!enable) begin
                div      <= '0;
                fill_idx <= '0;
            end else if (tick) begin
                div      <= '0;
                fill_idx <= complete ? '0 : fill_idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end

            // Every completed frame consumes a sequence number, dropped or not.
            if (complete) begin
                seq_cnt <= seq_cnt + 1'b1;
            end

            case (state)
                EMPTY: begin
                    if (complete) begin
                        read_bank       <= fill_bank;
                        fill_bank       <= ~fill_bank;
                        bus.frame_seq   <= seq_cnt;
                        bus.frame_valid <= 1'b1;
                        state           <= PUBLISHED;
                    end
                end
                PUBLISHED: begin
                    if (bus.frame_ack) begin
                        if (complete) begin
                            read_bank       <= fill_bank;
                            fill_bank       <= ~fill_bank;
                            bus.frame_seq   <= seq_cnt;
                        end else begin
                            bus.frame_valid <= 1'b0;
                            state           <= EMPTY;
                        end
                    end else if (complete && bus.overrun_cnt != 8'hFF) begin
                        bus.overrun_cnt <= bus.overrun_cnt + 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_frame_sampler.sv
// Randomized self-checking bench for gpio_frame_sampler: a frame-level reference model for a small
// configuration plus a default-parameter instance for the long-frame latency check.
module tb_gpio_frame_sampler;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int D  = 4;
    localparam int SW = 8;
    localparam int BL = 18;
    localparam int BD = 556;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          enable;
    logic [DW-1:0] sample_in;
    logic          big_rst_n;
    logic          big_enable;
    logic [15:0]   big_sample_in;

    gpio_frame_sampler_if #(.DATA_W(DW), .FRAME_LEN(L), .SEQ_W(SW)) bus ();
    gpio_frame_sampler_if #(.DATA_W(16), .FRAME_LEN(BL), .SEQ_W(8)) big_bus ();

    gpio_frame_sampler #(.DATA_W(DW), .FRAME_LEN(L), .SAMPLE_DIV(D), .SEQ_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .bus(bus.master)
    );

    gpio_frame_sampler big_dut (
        .clk(clk), .rst_n(big_rst_n), .enable(big_enable), .sample_in(big_sample_in),
        .bus(big_bus.master)
    );

    int checks = 0;
    int errs   = 0;

    // Reference model state: frames as sample lists, timing as counts of enabled clocks.
    int            m_cnt;
    logic [DW-1:0] m_dl [2];
    logic [DW-1:0] m_fill [$];
    logic [DW-1:0] m_held [L];
    bit            m_known;
    bit            m_valid;
    int            m_seq;
    int            m_fseq;
    int            m_over;
    logic [DW-1:0] m_rd;
    bit            m_rd_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit ak, input int addr,
                              input logic [DW-1:0] din);
        logic [DW-1:0] stored;
        bit            tick;
        bit            done;
        if (!r) begin
            m_cnt = 0; m_dl[0] = '0; m_dl[1] = '0; m_fill.delete();
            m_known = 0; m_valid = 0; m_seq = 0; m_fseq = 0; m_over = 0;
            m_rd = '0; m_rd_known = 1;
            return;
        end
        stored     = m_dl[0];
        m_dl[0]    = m_dl[1];
        m_dl[1]    = din;
        m_rd_known = m_known || (addr >= L);
        m_rd       = (addr >= L) ? '0 : m_held[addr];
        tick = 0;
        if (en) begin
            m_cnt++;
            if (m_cnt == D) begin
                m_cnt = 0;
                tick  = 1;
            end
        end else begin
            m_cnt = 0;
            m_fill.delete();
        end
        done = 0;
        if (tick) begin
            m_fill.push_back(stored);
            if (m_fill.size() == L) done = 1;
        end
        if (done) begin
            if (m_valid && !ak) begin
                if (m_over < 255) m_over++;
            end else begin
                for (int i = 0; i < L; i++) m_held[i] = m_fill[i];
                m_known = 1;
                m_valid = 1;
                m_fseq  = m_seq;
            end
            m_seq = (m_seq + 1) % (1 << SW);
            m_fill.delete();
        end else if (ak && m_valid) begin
            m_valid = 0;
        end
    endtask

    task automatic check_output();
        check("frame_valid", bus.frame_valid, m_valid);
        check("frame_seq", bus.frame_seq, m_fseq);
        check("overrun_cnt", bus.overrun_cnt, m_over);
        if (m_rd_known) check("rd_data", bus.rd_data, m_rd);
    endtask

    task automatic apply_stimulus(input bit r, input bit en, input bit ak, input int addr);
        logic [DW-1:0] din;
        din            = DW'($urandom);
        rst_n          = r;
        enable         = en;
        bus.frame_ack  = ak;
        bus.rd_addr    = addr[1:0];
        sample_in      = din;
        @(posedge clk);
        model_edge(r, en, ak, addr, din);
        #1;
        check_output();
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (bus.frame_valid !== 1'b1 && n < bound) begin
            apply_stimulus(1, 1, 0, $urandom_range(0, L - 1));
            n++;
        end
        check("wait_valid", bus.frame_valid, 1);
    endtask

    initial begin
        int n;
        int k;
        int hold;
        rst_n = 0; enable = 0; sample_in = '0; bus.frame_ack = 0; bus.rd_addr = '0;
        big_rst_n = 0; big_enable = 0; big_sample_in = '0;
        big_bus.frame_ack = 0; big_bus.rd_addr = '0;

        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0);
        big_rst_n = 1;

        // First frame appears after exactly FRAME_LEN sample periods.
        wait_valid(40, n);
        check("p1_latency", n, L * D);
        for (int a = 0; a < L; a++) apply_stimulus(1, 1, 0, a);
        check("p1_seq", bus.frame_seq, 0);

        // Prompt acks: consecutive sequence numbers, no overruns.
        apply_stimulus(0, 0, 0, 0);
        for (int f = 0; f < 5; f++) begin
            wait_valid(40, n);
            check("p2_seq", bus.frame_seq, f);
            hold = $urandom_range(0, 6);
            for (int h = 0; h < hold; h++) apply_stimulus(1, 1, 0, $urandom_range(0, L - 1));
            apply_stimulus(1, 1, 1, $urandom_range(0, L - 1));
        end
        check("p2_over", bus.overrun_cnt, 0);

        // No acks: held frame survives three overruns; gap shows in the next sequence number.
        apply_stimulus(0, 0, 0, 0);
        wait_valid(40, n);
        k = 0;
        while (m_over < 3 && k < 80) begin
            apply_stimulus(1, 1, 0, $urandom_range(0, L - 1));
            k++;
        end
        check("p3_over", bus.overrun_cnt, 3);
        check("p3_seq", bus.frame_seq, 0);
        check("p3_valid", bus.frame_valid, 1);
        apply_stimulus(1, 1, 1, $urandom_range(0, L - 1));
        wait_valid(40, n);
        check("p3_seq_after", bus.frame_seq, 4);

        // Ack landing on the completion cycle republishes without an overrun.
        k = 0;
        while (!(m_cnt == D - 1 && m_fill.size() == L - 1) && k < 40) begin
            apply_stimulus(1, 1, 0, $urandom_range(0, L - 1));
            k++;
        end
        apply_stimulus(1, 1, 1, $urandom_range(0, L - 1));
        check("p4_valid", bus.frame_valid, 1);
        check("p4_seq", bus.frame_seq, 5);
        check("p4_over", bus.overrun_cnt, 3);

        // Enable drop mid-frame restarts filling from index 0.
        k = 0;
        while (m_fill.size() != 2 && k < 40) begin
            apply_stimulus(1, 1, 0, $urandom_range(0, L - 1));
            k++;
        end
        for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, $urandom_range(0, L - 1));
        check("p5_valid", bus.frame_valid, 1);
        check("p5_seq", bus.frame_seq, 5);
        check("p5_over", bus.overrun_cnt, 3);
        n = 0;
        do begin
            apply_stimulus(1, 1, 0, $urandom_range(0, L - 1));
            n++;
        end while (bus.overrun_cnt == 8'd3 && n < 40);
        check("p5_refill", n, L * D);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 0, $urandom_range(0, L - 1));
        apply_stimulus(0, 1, 0, $urandom_range(0, L - 1));
        check("p5_rst_valid", bus.frame_valid, 0);
        check("p5_rst_seq", bus.frame_seq, 0);
        check("p5_rst_over", bus.overrun_cnt, 0);
        check("p5_rst_rd", bus.rd_data, 0);

        // Default-parameter instance: constant input, full-length frame latency and readback.
        big_sample_in = 16'hA5A5;
        @(posedge clk);
        n = 1;
        @(posedge clk);
        n = 2;
        #1;
        big_enable = 1;
        while (big_bus.frame_valid !== 1'b1 && n < 12000) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("p6_valid", big_bus.frame_valid, 1);
        checks++;
        assert (n >= 2 + BL * BD - 1 && n <= 2 + BL * BD + 1) else begin
            errs++;
            $error("[TB] FAIL p6_latency observed=%0d expected=%0d+-1", n, 2 + BL * BD);
        end
        check("p6_seq", big_bus.frame_seq, 0);
        for (int a = 0; a < 32; a++) begin
            big_bus.rd_addr = a[4:0];
            @(posedge clk);
            #1;
            check("p6_rd", big_bus.rd_data, (a < BL) ? 32'h0000A5A5 : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
